osc_tick_gen: RTL and testbench
===============================

OSC_TICK_GEN -- requirements
Module: osc_tick_gen

Interface
REQ-001 Parameter NCH, default 2, number of tick channels (legal 1..8).
REQ-002 Parameter DW, default 16, divisor/counter width in bits (legal 4..24).
REQ-003 Parameter DIV_INIT, default 26, reset divisor loaded into every channel.
REQ-004 CLK  input  1  sole clock, from the fabric RC oscillator output (50 MHz nominal).
REQ-005 RESET  input  1  reset, synchronous, active-high.
REQ-006 CH_EN  input  NCH  per-channel run enable.
REQ-007 WR_REQ  input  1  divisor-update request, level, held until WR_ACK.
REQ-008 WR_SEL  input  max(1,clog2(NCH))  target channel index, stable while WR_REQ high.
REQ-009 WR_DIV  input  DW  new divisor, stable while WR_REQ high.
REQ-010 WR_ACK  output  1  one-cycle update-complete pulse.
REQ-011 TICK  output  NCH  per-channel single-cycle clock-enable pulses.
REQ-012 TOGGLE  output  NCH  per-channel square wave at half tick rate (macro-dependent).

Function
REQ-013 Each channel SHALL hold a DW-bit divisor DIVR[i] and a DW-bit counter CNT[i]; tick period = DIVR[i]+1 CLK cycles.
REQ-014 With CH_EN[i] high: CNT[i] SHALL go to 0 when CNT[i]==DIVR[i], else increment by 1; no wrap beyond DIVR[i] is permitted.
REQ-015 TICK[i] SHALL be registered: high in the cycle after a cycle with CH_EN[i]=1 and CNT[i]==DIVR[i]; first TICK after CH_EN rise from CNT=0 asserts at edge DIVR+1.
REQ-016 DIVR[i]=0 SHALL give TICK[i] continuously high from edge 1 after CH_EN[i] rises.
REQ-017 With CH_EN[i] low: CNT[i] SHALL be forced to 0 and TICK[i] SHALL be 0 the next cycle; CH_EN falling in a terminal-count cycle SHALL suppress that tick.
REQ-018 Update FSM states IDLE, WAIT, ACK; IDLE->WAIT on WR_REQ=1; WAIT->ACK when applied; ACK->IDLE unconditionally after one cycle.
REQ-019 In WAIT, WR_DIV SHALL be written to DIVR[WR_SEL] in the cycle the selected channel is at terminal count (CNT==DIVR, CH_EN=1) or in the first WAIT cycle if that channel's CH_EN is low.
REQ-020 The new divisor SHALL govern the period starting at the following CNT=0; the current period SHALL never be truncated or extended.
REQ-021 WR_ACK SHALL be high for exactly the ACK-state cycle; requester drops WR_REQ after WR_ACK; WR_REQ still high in IDLE after ACK starts a new update.
REQ-022 WR_SEL >= NCH SHALL be ignored (no DIVR changes) but still acknowledged one cycle after WAIT entry.
REQ-023 Channels not selected SHALL be unaffected by any update.

Reset
REQ-024 RESET high at a CLK edge SHALL set CNT=0, DIVR=DIV_INIT, TICK=0, TOGGLE=0, WR_ACK=0, FSM=IDLE for all channels.
REQ-025 RESET during WAIT SHALL discard the pending update with no WR_ACK.
REQ-026 RESET SHALL dominate CH_EN and WR_REQ in the same cycle.

Configuration
REQ-027 Macro OSC_TICK_GEN_TOGGLE_EN defined: TOGGLE[i] SHALL be a flop inverting in the cycle TICK[i] is high; held when CH_EN[i] low.
REQ-028 Macro undefined: TOGGLE SHALL be tied 0 and no toggle flops SHALL be synthesised; all other behaviour unchanged.

Verification
REQ-029 NCH=2, DIV_INIT=26, CH_EN=01 after reset -> TICK[0] first high at edge 27, then every 27 cycles; TICK[1] stays 0.
REQ-030 Channel 0 running DIV=26, WR_REQ with SEL=0 DIV=9 at CNT=5 -> no tick earlier than old period, WR_ACK the cycle after CNT=26, subsequent period 10.
REQ-031 CH_EN[1]=0, WR_REQ SEL=1 DIV=0 -> WR_ACK 2 cycles after WR_REQ rise; CH_EN[1]=1 -> TICK[1] high continuously from edge 1.
REQ-032 WR_SEL=3 with NCH=2 -> WR_ACK within 2 cycles, both DIVR unchanged, tick periods unchanged.
REQ-033 RESET asserted while in WAIT -> no WR_ACK, DIVR back to 26, TICK=0 next cycle.
REQ-034 With OSC_TICK_GEN_TOGGLE_EN, DIV=3 -> TOGGLE[0] period 8 cycles, 50% duty; without macro TOGGLE=0 throughout.

Source files
------------

// File: rtl/osc_tick_gen.sv
// osc_tick_gen: per-channel tick dividers with glitch-free divisor update; optional toggle outputs under OSC_TICK_GEN_TOGGLE_EN
module osc_tick_gen #(
  parameter int NCH = 2,
  parameter int DW = 16,
  parameter int DIV_INIT = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic [NCH-1:0] ch_en,
  input  logic wr_req,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] wr_sel,
  input  logic [DW-1:0] wr_div,
  output logic wr_ack,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] toggle
);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic [DW-1:0] cnt [NCH];
  logic [DW-1:0] divr [NCH];
  logic [NCH-1:0] term, hit, apply;
  logic done;
  // terminal count per channel; an update lands only on a period boundary or on an idle channel
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      term[i] = ch_en[i] && cnt[i] == divr[i];
      hit[i] = wr_sel == SW'(i);
      apply[i] = state == WAIT && hit[i] && (term[i] || !ch_en[i]);
    end
    done = state == WAIT && (|apply || !(|hit));
  end
  // counters, divisors, ticks and the update handshake FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ack <= 1'b0;
      tick <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        divr[i] <= DW'(DIV_INIT);
      end
    end else begin
      state <= state == IDLE ? (wr_req ? WAIT : IDLE) : state == WAIT ? (done ? ACK : WAIT) : IDLE;
      wr_ack <= done;
      tick <= term;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= term[i] || !ch_en[i] ? '0 : cnt[i] + DW'(1);
        if (apply[i]) divr[i] <= wr_div;
      end
    end
  end
`ifdef OSC_TICK_GEN_TOGGLE_EN
  logic [NCH-1:0] tog;
  // half-rate square wave, frozen while the channel is disabled
  always_ff @(posedge clk) tog <= reset ? '0 : tog ^ (tick & ch_en);
  assign toggle = tog;
`else
  assign toggle = '0;
`endif
endmodule

// File: tb/tb_osc_tick_gen.sv
// tb_osc_tick_gen: scoreboard bench, expected pulse cycles queued by stimulus, checked by a monitor
module tb_osc_tick_gen;
  logic clk = 1'b0;
  logic reset, wr_req, wr_ack;
  logic [2:0] ch_en, tick, toggle;
  logic [1:0] wr_sel;
  logic [15:0] wr_div;
  int cyc = 0, total = 0, passed = 0, e0, b, d, g, f;
  int q [4][$];
  logic hist [0:1023];
  string names [4] = '{"tick0", "tick1", "tick2", "wr_ack"};

  osc_tick_gen #(.NCH(3), .DW(16), .DIV_INIT(26)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .wr_req(wr_req), .wr_sel(wr_sel),
    .wr_div(wr_div), .wr_ack(wr_ack), .tick(tick), .toggle(toggle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  task automatic observe(int k);
    int e;
    total++;
    if (q[k].size() == 0) $display("FAIL %s unexpected pulse at cycle %0d, expected none", names[k], cyc);
    else begin
      e = q[k].pop_front();
      if (e == cyc) passed++;
      else $display("FAIL %s pulse at cycle %0d, expected at cycle %0d", names[k], cyc, e);
    end
  endtask

  task automatic push(int k, int from, int step, int to);
    for (int c = from; c <= to; c += step) q[k].push_back(c);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor: every output pulse must match the head of its queue
  always @(negedge clk) begin
    hist[cyc[9:0]] = toggle[0];
    for (int k = 0; k < 3; k++) if (tick[k] === 1'b1) observe(k);
    if (wr_ack === 1'b1) observe(3);
`ifndef OSC_TICK_GEN_TOGGLE_EN
    if (cyc > 0) chk("toggle_tied", int'(toggle), 0);
`endif
  end

  initial begin
    reset = 1'b1; ch_en = '0; wr_req = 1'b0; wr_sel = '0; wr_div = '0;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ack", int'(wr_ack), 0);
    chk("rst_toggle", int'(toggle), 0);
    e0 = cyc;
    reset = 1'b0; ch_en = 3'b001;
    push(0, e0 + 27, 27, e0 + 81);
    push(0, e0 + 108, 10, e0 + 208);
    push(0, e0 + 212, 4, e0 + 252);
    // divisor 26 -> 9 requested at CNT=5: old period completes, ack with the tick
    wait_cyc(e0 + 86);
    wr_req = 1'b1; wr_sel = 2'd0; wr_div = 16'd9;
    q[3].push_back(e0 + 108);
    wait_cyc(e0 + 108);
    wr_req = 1'b0;
    // idle channel 1 updated to 0: immediate apply, then continuous ticks
    b = e0 + 140;
    wait_cyc(b);
    wr_req = 1'b1; wr_sel = 2'd1; wr_div = 16'd0;
    q[3].push_back(b + 2);
    wait_cyc(b + 2);
    wr_req = 1'b0;
    wait_cyc(b + 4);
    ch_en = 3'b011;
    push(1, b + 5, 1, b + 14);
    wait_cyc(b + 14);
    ch_en = 3'b001;
    // out-of-range select: acked, no divisor changes
    d = e0 + 160;
    wait_cyc(d);
    wr_req = 1'b1; wr_sel = 2'd3; wr_div = 16'd5;
    q[3].push_back(d + 2);
    wait_cyc(d + 2);
    wr_req = 1'b0;
    wait_cyc(d + 4);
    ch_en = 3'b011;
    push(1, d + 5, 1, d + 7);
    wait_cyc(d + 7);
    ch_en = 3'b001;
    // divisor 9 -> 3 requested mid-period
    g = e0 + 200;
    wait_cyc(g);
    wr_req = 1'b1; wr_sel = 2'd0; wr_div = 16'd3;
    q[3].push_back(e0 + 208);
    wait_cyc(e0 + 208);
    wr_req = 1'b0;
`ifdef OSC_TICK_GEN_TOGGLE_EN
    for (int c = e0 + 221; c <= e0 + 250; c++) begin
      wait_cyc(c);
      chk("toggle_half", int'(toggle[0]), int'(!hist[10'(c - 4)]));
      chk("toggle_full", int'(toggle[0]), int'(hist[10'(c - 8)]));
    end
`endif
    // reset while an update is pending in WAIT, with ch_en and wr_req held high
    f = e0 + 252;
    wait_cyc(f);
    wr_req = 1'b1; wr_sel = 2'd0; wr_div = 16'd7;
    wait_cyc(f + 2);
    reset = 1'b1;
    wait_cyc(f + 3);
    chk("wait_rst_tick", int'(tick), 0);
    chk("wait_rst_ack", int'(wr_ack), 0);
    chk("wait_rst_toggle", int'(toggle), 0);
    reset = 1'b0; wr_req = 1'b0;
    push(0, f + 30, 27, f + 57);
    wait_cyc(f + 70);
    for (int k = 0; k < 4; k++)
      while (q[k].size() > 0) begin
        total++;
        $display("FAIL %s missing pulse: got none, expected at cycle %0d", names[k], q[k].pop_front());
      end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
